// File: rtl/seg_stim_pkg.sv
`default_nettype none
// ============================================================================
// seg_stim_pkg : shared types for the scripted Segway stimulus sequencer
// Rev 1.0
// ============================================================================
package seg_stim_pkg;

    localparam int c_DLY_W  = 24;
    localparam int c_LEAN_W = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        WAIT_DLY = 3'd2,
        SEND     = 3'd3,
        WAIT_TX  = 3'd4,
        LEAN     = 3'd5,
        NEXT     = 3'd6
    } state_t;

    typedef struct packed {
        logic [c_DLY_W-1:0]         dly;
        logic                       cmd_vld;
        logic [7:0]                 cmd;
        logic signed [c_LEAN_W-1:0] lean;
        logic                       ramp;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/seg_stim_fifo.sv
`default_nettype none
// ============================================================================
// seg_stim_fifo : synchronous script-entry FIFO with flush
// Rev 1.0
// ============================================================================
module seg_stim_fifo
    import seg_stim_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   push,
    input  entry_t wr_data,
    input  logic   pop,
    output entry_t rd_data,
    output logic   full,
    output logic   empty
);
    localparam int c_AW = $clog2(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop_ok  = pop && !empty;
    // A pop frees the head slot this cycle, so a push is accepted even when full.
    assign w_push_ok = push && (!full || w_pop_ok);
    assign rd_data   = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !flush) r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/seg_stim_seq.sv
`default_nettype none
// ============================================================================
// seg_stim_seq : timed, abortable script sequencer driving uart_tx and rider_lean
// Rev 1.0
// ============================================================================
module seg_stim_seq
    import seg_stim_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int LEAN_W    = c_LEAN_W,
    parameter int DLY_W     = c_DLY_W,
    parameter int RAMP_STEP = 16,
    parameter int RAMP_DIV  = 1024,
    parameter int TX_TMO    = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DLY_W-1:0]         wr_dly,
    input  logic                     wr_cmd_vld,
    input  logic [7:0]               wr_cmd,
    input  logic signed [LEAN_W-1:0] wr_lean,
    input  logic                     wr_ramp,
    output logic                     full,
    output logic                     empty,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     send_cmd,
    output logic [7:0]               cmd,
    input  logic                     cmd_sent,
    output logic signed [LEAN_W-1:0] rider_lean
);
    localparam int c_PRE_W = $clog2(RAMP_DIV) + 1;
    localparam int c_TMO_W = $clog2(TX_TMO + 1);
    localparam logic [c_PRE_W-1:0]     c_PRE_MAX = c_PRE_W'(RAMP_DIV - 1);
    localparam logic [c_TMO_W-1:0]     c_TMO_MAX = c_TMO_W'(TX_TMO - 1);
    localparam logic signed [LEAN_W:0] c_STEP    = (LEAN_W+1)'(RAMP_STEP);

    state_t                   r_state;
    state_t                   w_next;
    entry_t                   w_wr_entry;
    entry_t                   w_head;
    logic                     w_pop;
    logic [DLY_W-1:0]         r_dly_cnt;
    logic                     r_cmd_vld;
    logic                     r_ramp;
    logic [7:0]               r_cmd;
    logic signed [LEAN_W-1:0] r_tgt;
    logic signed [LEAN_W-1:0] r_lean;
    logic [c_PRE_W-1:0]       r_pre;
    logic [c_TMO_W-1:0]       r_tmo;
    logic                     r_err;
    logic                     w_tick;
    logic                     w_tmo_hit;
    logic signed [LEAN_W:0]   w_diff;
    logic signed [LEAN_W:0]   w_ramp_val;

    always_comb begin
        w_wr_entry         = '0;
        w_wr_entry.dly     = wr_dly;
        w_wr_entry.cmd_vld = wr_cmd_vld;
        w_wr_entry.cmd     = wr_cmd;
        w_wr_entry.lean    = wr_lean;
        w_wr_entry.ramp    = wr_ramp;
    end

    assign w_pop = (r_state == LOAD);

    seg_stim_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort),
        .push    (wr_en),
        .wr_data (w_wr_entry),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (full),
        .empty   (empty)
    );

    assign w_tick    = (r_pre == c_PRE_MAX);
    assign w_tmo_hit = (r_state == WAIT_TX) && (r_tmo == c_TMO_MAX);

    // One extra bit of headroom so a step toward +/-max never wraps.
    assign w_diff = $signed({r_tgt[LEAN_W-1], r_tgt}) - $signed({r_lean[LEAN_W-1], r_lean});

    always_comb begin
        w_ramp_val = $signed({r_tgt[LEAN_W-1], r_tgt});
        if (w_diff > c_STEP)
            w_ramp_val = $signed({r_lean[LEAN_W-1], r_lean}) + c_STEP;
        else if (w_diff < -c_STEP)
            w_ramp_val = $signed({r_lean[LEAN_W-1], r_lean}) - c_STEP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:     if (start && !empty) w_next = LOAD;
                LOAD:     w_next = WAIT_DLY;
                // Occupies max(dly,1) cycles.
                WAIT_DLY: if (r_dly_cnt <= DLY_W'(1)) w_next = r_cmd_vld ? SEND : LEAN;
                SEND:     w_next = WAIT_TX;
                WAIT_TX:  if (cmd_sent || w_tmo_hit) w_next = LEAN;
                LEAN:     if (!r_ramp || (r_lean == r_tgt)) w_next = NEXT;
                NEXT:     w_next = empty ? IDLE : LOAD;
                default:  w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        send_cmd = (r_state == SEND);
        busy     = (r_state != IDLE);
        done     = !abort && empty &&
                   ((r_state == NEXT) || ((r_state == IDLE) && start));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dly_cnt <= '0;
            r_cmd_vld <= 1'b0;
            r_ramp    <= 1'b0;
            r_cmd     <= '0;
            r_tgt     <= '0;
            r_lean    <= '0;
            r_pre     <= '0;
            r_tmo     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == LOAD) begin
                r_dly_cnt <= w_head.dly;
                r_cmd_vld <= w_head.cmd_vld;
                r_ramp    <= w_head.ramp;
                r_tgt     <= w_head.lean;
                r_pre     <= '0;
                if (w_head.cmd_vld) r_cmd <= w_head.cmd;
            end else begin
                if (r_state == WAIT_DLY && r_dly_cnt != '0)
                    r_dly_cnt <= r_dly_cnt - DLY_W'(1);
                if (r_state == LEAN && r_ramp)
                    r_pre <= w_tick ? '0 : r_pre + c_PRE_W'(1);
            end

            if (r_state == SEND)         r_tmo <= '0;
            else if (r_state == WAIT_TX) r_tmo <= r_tmo + c_TMO_W'(1);

            if (r_state == LEAN && !abort) begin
                if (!r_ramp)     r_lean <= r_tgt;
                else if (w_tick) r_lean <= LEAN_W'(w_ramp_val);
            end

            if (r_state == IDLE && start && !abort)        r_err <= 1'b0;
            if (w_tmo_hit && !cmd_sent && !abort)           r_err <= 1'b1;
            if (wr_en && full && !w_pop && !abort)          r_err <= 1'b1;
        end
    end

    assign cmd        = r_cmd;
    assign err        = r_err;
    assign rider_lean = r_lean;

endmodule
`default_nettype wire

// File: tb/tb_seg_stim_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_seg_stim_seq : scoreboard bench for seg_stim_seq with an abstract script model
// Rev 1.0
// ============================================================================
module tb_seg_stim_seq;
    localparam int DEPTH     = 8;
    localparam int LEAN_W    = 16;
    localparam int DLY_W     = 24;
    localparam int RAMP_STEP = 16;
    localparam int RAMP_DIV  = 4;
    localparam int TX_TMO    = 32;
    localparam int K_SEND    = 0;
    localparam int K_LEAN    = 1;
    localparam int K_DONE    = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     wr_en = 1'b0;
    logic [DLY_W-1:0]         wr_dly = '0;
    logic                     wr_cmd_vld = 1'b0;
    logic [7:0]               wr_cmd = '0;
    logic signed [LEAN_W-1:0] wr_lean = '0;
    logic                     wr_ramp = 1'b0;
    logic                     full, empty, busy, done, err, send_cmd;
    logic                     start = 1'b0;
    logic                     abort = 1'b0;
    logic [7:0]               cmd;
    logic                     cmd_sent;
    logic signed [LEAN_W-1:0] rider_lean;

    seg_stim_seq #(
        .DEPTH(DEPTH), .LEAN_W(LEAN_W), .DLY_W(DLY_W),
        .RAMP_STEP(RAMP_STEP), .RAMP_DIV(RAMP_DIV), .TX_TMO(TX_TMO)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_dly(wr_dly), .wr_cmd_vld(wr_cmd_vld),
        .wr_cmd(wr_cmd), .wr_lean(wr_lean), .wr_ramp(wr_ramp), .full(full), .empty(empty),
        .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
        .send_cmd(send_cmd), .cmd(cmd), .cmd_sent(cmd_sent), .rider_lean(rider_lean)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; int val; } ev_t;
    ev_t exp_q[$];
    int  chg_cyc[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  model_lean = 0;
    int  prev_lean = 0;
    int  send_cyc = -1, done_cyc = -1, sent_cyc = -1, start_cyc = 0;
    int  tx_lat = 3;
    bit  tx_respond = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int kind, input int val, input string name);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event value %0d at cycle %0d", name, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                errors++;
                $display("FAIL %s: got kind %0d value %0d expected kind %0d value %0d at cycle %0d",
                         name, kind, val, e.kind, e.val, cyc);
            end
        end
    endtask

    // Monitor: every observable event is matched against the scoreboard in order.
    always @(negedge clk) begin
        if (rst) begin
            prev_lean = 0;
        end else begin
            if (send_cmd) begin
                send_cyc = cyc;
                sb_pop(K_SEND, int'(cmd), "send_cmd");
            end
            if (int'(rider_lean) != prev_lean) begin
                chg_cyc.push_back(cyc);
                sb_pop(K_LEAN, int'(rider_lean), "rider_lean");
                prev_lean = int'(rider_lean);
            end
            if (done) begin
                done_cyc = cyc;
                sb_pop(K_DONE, 0, "done");
            end
        end
    end

    // uart_tx stand-in: answers each trmt with tx_done after tx_lat cycles.
    initial begin
        cmd_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && send_cmd && tx_respond) begin
                repeat (tx_lat) @(posedge clk);
                #1 cmd_sent = 1'b1;
                sent_cyc = cyc;
                @(posedge clk);
                #1 cmd_sent = 1'b0;
            end
        end
    end

    function automatic void model_entry(input bit cv, input int c, input int lean, input bit ramp);
        int cur;
        if (cv) exp_q.push_back('{kind: K_SEND, val: c});
        if (ramp) begin
            cur = model_lean;
            while (cur != lean) begin
                if (lean - cur > RAMP_STEP)      cur = cur + RAMP_STEP;
                else if (cur - lean > RAMP_STEP) cur = cur - RAMP_STEP;
                else                             cur = lean;
                exp_q.push_back('{kind: K_LEAN, val: cur});
            end
        end else if (lean != model_lean) begin
            exp_q.push_back('{kind: K_LEAN, val: lean});
        end
        model_lean = lean;
    endfunction

    task automatic push(input int dly, input bit cv, input int c, input int lean,
                        input bit ramp, input bit model);
        wr_en = 1'b1; wr_dly = DLY_W'(dly); wr_cmd_vld = cv; wr_cmd = 8'(c);
        wr_lean = LEAN_W'(lean); wr_ramp = ramp;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (model) model_entry(cv, c, lean, ramp);
    endtask

    task automatic do_start();
        start_cyc = cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (busy && n < max) begin @(posedge clk); #1; n++; end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles", name, n);
            abort = 1'b1; cycles(1); abort = 1'b0;
            exp_q.delete();
            model_lean = int'(rider_lean);
        end
        cycles(2);
        chk({name, " scoreboard drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t;
        bit cv, rp;
        cycles(3);
        chk("reset send_cmd", send_cmd, 0);
        chk("reset cmd", cmd, 0);
        chk("reset rider_lean", rider_lean, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset empty", empty, 1);
        chk("reset full", full, 0);
        rst = 1'b0;
        cycles(2);

        // Command entry: send latency and done timing after tx_done.
        tx_lat = 10;
        push(3, 1, 'h67, 0, 0, 1);
        exp_q.push_back('{kind: K_DONE, val: 0});
        do_start();
        wait_idle(200, "t1");
        chk("t1 send at LOAD+4", send_cyc - start_cyc, 5);
        chk("t1 done 2 after cmd_sent", done_cyc - sent_cyc, 2);
        tx_lat = 3;

        // Ramp up to 100 then down to -50.
        push(0, 0, 0, 100, 1, 1);
        push(0, 0, 0, -50, 1, 1);
        exp_q.push_back('{kind: K_DONE, val: 0});
        chg_cyc.delete();
        do_start();
        wait_idle(500, "t2");
        chk("t2 change count", chg_cyc.size(), 17);
        if (chg_cyc.size() >= 7)
            for (int i = 1; i < 7; i++) chk("t2 ramp spacing", chg_cyc[i] - chg_cyc[i-1], RAMP_DIV);

        // Ramp endpoints at the extremes of the lean range.
        push(0, 0, 0, 32760, 0, 1);
        push(0, 0, 0, 32767, 1, 1);
        push(0, 0, 0, -32760, 0, 1);
        push(0, 0, 0, -32768, 1, 1);
        exp_q.push_back('{kind: K_DONE, val: 0});
        do_start();
        wait_idle(200, "boundary");

        // Overflow: the extra entry is dropped and flags err.
        for (int i = 0; i < DEPTH; i++) push(0, 0, 0, (i + 1) * 10, 0, 1);
        chk("t3 full", full, 1);
        chk("t3 err before overflow", err, 0);
        push(0, 1, 'hAA, 999, 0, 0);
        chk("t3 err after overflow", err, 1);
        exp_q.push_back('{kind: K_DONE, val: 0});
        do_start();
        chk("t3 err cleared by start", err, 0);
        wait_idle(500, "t3");

        // tx_done never arrives: timeout sets err and script continues.
        tx_respond = 1'b0;
        push(2, 1, 'h31, 200, 0, 1);
        push(1, 0, 0, -300, 0, 1);
        exp_q.push_back('{kind: K_DONE, val: 0});
        do_start();
        wait_idle(500, "t4");
        chk("t4 err after timeout", err, 1);
        tx_respond = 1'b1;

        // Entry appended while the script runs.
        push(20, 1, 'h12, 55, 0, 1);
        push(20, 0, 0, -5, 1, 1);
        do_start();
        push(3, 1, 'h34, 1234, 0, 1);
        exp_q.push_back('{kind: K_DONE, val: 0});
        wait_idle(500, "t7");

        // Randomised scripts.
        for (int r = 0; r < 5; r++) begin
            tx_lat = $urandom_range(1, 6);
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                cv = 1'($urandom_range(0, 1));
                rp = 1'($urandom_range(0, 1));
                if (rp) begin
                    t = model_lean + int'($urandom_range(0, 400)) - 200;
                    if (t > 32767)  t = 32767;
                    if (t < -32768) t = -32768;
                end else begin
                    t = int'($urandom_range(0, 65535)) - 32768;
                end
                push($urandom_range(0, 5), cv, $urandom_range(0, 255), t, rp, 1);
            end
            exp_q.push_back('{kind: K_DONE, val: 0});
            do_start();
            wait_idle(3000, "random");
        end
        chk("random err clear", err, 0);

        // Abort during WAIT_DLY with three entries queued.
        for (int i = 0; i < 3; i++) push(40, 1, 'h55, 777, 0, 0);
        do_start();
        cycles(5);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        chk("t5 busy after abort", busy, 0);
        chk("t5 empty after abort", empty, 1);
        cycles(60);
        chk("t5 rider_lean held", rider_lean, model_lean);
        chk("t5 no events", exp_q.size(), 0);

        // Reset mid-ramp, then start on an empty FIFO.
        push(0, 0, 0, model_lean + 500, 1, 1);
        do_start();
        cycles(30);
        rst = 1'b1;
        #1;
        chk("t6 rider_lean at rst", rider_lean, 0);
        chk("t6 busy at rst", busy, 0);
        chk("t6 send_cmd at rst", send_cmd, 0);
        chk("t6 empty at rst", empty, 1);
        exp_q.delete();
        model_lean = 0;
        cycles(2);
        rst = 1'b0;
        cycles(2);
        exp_q.push_back('{kind: K_DONE, val: 0});
        do_start();
        chk("t6 done on empty start", done_cyc, start_cyc);
        chk("t6 busy stays 0", busy, 0);
        cycles(3);
        chk("t6 scoreboard drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
